// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: merges per-stage stall requests into the
// bubble/hold vector and sequences multi-cycle EX operations.
module pipe_stall_ctrl #(
  parameter int CNT_W = 16,
  parameter int MC_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             ex_mc_start,
  input  logic [MC_W-1:0]  ex_mc_cycles,
  input  logic             mem_stall_req,
  output logic [5:0]       stall,
  output logic             ex_mc_busy,
  output logic             ex_mc_done,
  output logic [CNT_W-1:0] stall_cycles
);

  // state | meaning
  // IDLE  | no multi-cycle op in flight; ex_mc_start is accepted
  // BUSY  | EX unit computing; cnt = further stalled BUSY cycles before done
  // HOLD  | op finished, instruction still in EX behind a MEM stall
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [MC_W-1:0] cnt, cnt_nxt;
  logic            ex_req;
  logic            done_raw;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ex_req    = 1'b0;
    done_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (ex_mc_start) begin
          if (ex_mc_cycles >= MC_W'(2)) begin
            ex_req    = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = ex_mc_cycles - MC_W'(2);
          end else begin
            // length 0 or 1 completes in the start cycle without stalling EX
            done_raw  = 1'b1;
            state_nxt = mem_stall_req ? HOLD : IDLE;
          end
        end
      end
      BUSY: begin
        // counts down regardless of other stalls: the EX unit runs on its own
        if (cnt != '0) begin
          ex_req  = 1'b1;
          cnt_nxt = cnt - MC_W'(1);
        end else begin
          done_raw  = 1'b1;
          state_nxt = mem_stall_req ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!mem_stall_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Highest requesting stage wins; the vector covers that stage and all older ones.
  always_comb begin
    stall = 6'b000000;
    if (!reset) begin
      if (mem_stall_req)     stall = 6'b011111;
      else if (ex_req)       stall = 6'b001111;
      else if (id_stall_req) stall = 6'b000111;
      else if (if_stall_req) stall = 6'b000011;
    end
  end

  assign ex_mc_busy = !reset && (state == BUSY);
  assign ex_mc_done = !reset && done_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall[0] && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-level reference model pushes
// expected outputs, a monitor compares them against the DUT each cycle.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 16;
  localparam int MC_W  = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             if_stall_req = 1'b0;
  logic             id_stall_req = 1'b0;
  logic             ex_mc_start = 1'b0;
  logic [MC_W-1:0]  ex_mc_cycles = '0;
  logic             mem_stall_req = 1'b0;
  logic [5:0]       stall;
  logic             ex_mc_busy;
  logic             ex_mc_done;
  logic [CNT_W-1:0] stall_cycles;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .MC_W(MC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_stall_req (if_stall_req),
    .id_stall_req (id_stall_req),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .mem_stall_req(mem_stall_req),
    .stall        (stall),
    .ex_mc_busy   (ex_mc_busy),
    .ex_mc_done   (ex_mc_done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]       stall;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: cycles left until the done cycle, plus a MEM-hold flag.
  int   m_rem  = 0;
  bit   m_hold = 0;
  int   m_cnt  = 0;

  task automatic drive(input bit rst, input bit ifr, input bit idr,
                       input bit st, input int n, input bit mem);
    exp_t e;
    bit   req, dn;
    int   k, len;
    @(posedge clk);
    #1;
    reset         = rst;
    if_stall_req  = ifr;
    id_stall_req  = idr;
    ex_mc_start   = st;
    ex_mc_cycles  = MC_W'(n);
    mem_stall_req = mem;
    e.cnt = CNT_W'(m_cnt);
    req = 0;
    dn  = 0;
    if (rst) begin
      e.stall = '0;
      e.busy  = 0;
      e.done  = 0;
      m_rem   = 0;
      m_hold  = 0;
      m_cnt   = 0;
    end else begin
      e.busy = (m_rem > 0);
      if (m_rem > 1) begin
        req = 1;
        m_rem--;
      end else if (m_rem == 1) begin
        dn = 1;
        m_rem = 0;
        m_hold = mem;
      end else if (m_hold) begin
        m_hold = mem;
      end else if (st) begin
        len = (n == 0) ? 1 : n;
        if (len == 1) begin
          dn = 1;
          m_hold = mem;
        end else begin
          req = 1;
          m_rem = len - 1;
        end
      end
      k = mem ? 4 : req ? 3 : idr ? 2 : ifr ? 1 : 0;
      e.stall = (k == 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
      e.done  = dn;
      if (e.stall[0] && m_cnt < CMAX) m_cnt++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (stall !== e.stall || ex_mc_busy !== e.busy ||
            ex_mc_done !== e.done || stall_cycles !== e.cnt) begin
          bad++;
          $display("FAIL cycle_out t=%0t got stall=%b busy=%b done=%b cnt=%0d want stall=%b busy=%b done=%b cnt=%0d",
                   $time, stall, ex_mc_busy, ex_mc_done, stall_cycles,
                   e.stall, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    repeat (2) @(posedge clk);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    drive(0, 0, 1, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 1, 4, 0);
    idle(5);
    drive(0, 0, 0, 1, 3, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 5, 1);
    idle(6);
    drive(0, 0, 0, 1, 0, 0);
    idle(1);
    drive(0, 0, 0, 1, 1, 0);
    idle(2);
    drive(0, 0, 0, 1, 31, 0);
    idle(5);
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    drive(0, 1, 0, 1, 6, 1);
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    idle(8);
    drive(0, 1, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      n = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 31);
      drive($urandom_range(0, 255) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0,
            n,
            $urandom_range(0, 3) == 0);
    end
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) drive(0, 1, 0, 0, 0, 0);
    idle(3);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
